// File: rtl/dmem_pkg.sv
// Shared definitions for the LSU data memory: RV32I load/store size codes, FSM encoding
// and the size/offset to byte-enable mapping.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_SPLIT_HI = 1'b1
    } state_t;

    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

    // Byte enables over an 8-byte window starting at the low word; hi selects the upper word's half.
    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off, input logic hi);
        logic [7:0] m;
        case (f3)
            F3_B, F3_BU: m = 8'h01;
            F3_H, F3_HU: m = 8'h03;
            default:     m = 8'h0F;
        endcase
        m = m << off;
        return hi ? m[7:4] : m[3:0];
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store data/byte-enables across a two-word window,
// and load shift, merge and sign/zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_lo_word,
    input  logic [31:0] i_hi_word,
    output logic [31:0] o_st_lo,
    output logic [31:0] o_st_hi,
    output logic [3:0]  o_be_lo,
    output logic [3:0]  o_be_hi,
    output logic [31:0] o_ld_data
);
    logic [5:0]  w_shamt;
    logic [63:0] w_st_wide;
    logic [31:0] w_ld_raw;

    assign w_shamt   = {i_offset, 3'b000};
    assign w_st_wide = {32'b0, i_wdata} << w_shamt;
    assign o_st_lo   = w_st_wide[31:0];
    assign o_st_hi   = w_st_wide[63:32];
    assign o_be_lo   = lane_mask(i_funct3, i_offset, 1'b0);
    assign o_be_hi   = lane_mask(i_funct3, i_offset, 1'b1);
    assign w_ld_raw  = 32'({i_hi_word, i_lo_word} >> w_shamt);

    always_comb begin
        o_ld_data = '0;
        case (i_funct3)
            F3_B:    o_ld_data = {{24{w_ld_raw[7]}}, w_ld_raw[7:0]};
            F3_H:    o_ld_data = {{16{w_ld_raw[15]}}, w_ld_raw[15:0]};
            F3_W:    o_ld_data = w_ld_raw;
            F3_BU:   o_ld_data = {24'b0, w_ld_raw[7:0]};
            F3_HU:   o_ld_data = {16'b0, w_ld_raw[15:0]};
            default: o_ld_data = '0;
        endcase
    end
endmodule

// File: rtl/lsu_data_memory.sv
// Word-organised RV32I data memory with byte-lane writes and a registered one-cycle response.
// Define DMEM_MISALIGN_SPLIT_EN to complete misaligned accesses (word-crossing ones in two cycles).
//   state       | meaning
//   ST_IDLE     | accepting requests; aligned/in-word accesses respond next cycle
//   ST_SPLIT_HI | second half of a word-crossing access: high word read or high lanes written
module lsu_data_memory
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);
    localparam int unsigned IW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    state_t        r_state;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept, w_in_range, w_legal, w_fault;
    logic [31:0]   w_rel;
    logic [IW-1:0] w_idx;
    logic [1:0]    w_off;
    logic [2:0]    w_size;
    logic [2:0]    w_al_f3;
    logic [1:0]    w_al_off;
    logic [31:0]   w_al_wdata, w_al_lo, w_al_hi;
    logic [31:0]   w_st_lo, w_st_hi, w_ld_data;
    logic [3:0]    w_be_lo, w_be_hi;
    logic          w_we;
    logic [IW-1:0] w_waddr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_wbe;

    assign req_ready  = (r_state == ST_IDLE) & ~reset;
    assign w_accept   = req_valid & req_ready;
    // Unsigned subtract: addresses below BASE_ADDR wrap high and fail the range check.
    assign w_rel      = req_addr - BASE_ADDR;
    assign w_in_range = {1'b0, w_rel} < SPAN;
    assign w_idx      = w_rel[IW+1:2];
    assign w_off      = w_rel[1:0];
    assign w_size     = access_size(req_funct3);

    always_comb begin
        w_legal = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: w_legal = 1'b1;
            F3_BU, F3_HU:     w_legal = ~req_write;
            default:          w_legal = 1'b0;
        endcase
    end

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic          w_cross, w_hi_oor, w_split;
    logic [2:0]    r_f3;
    logic [1:0]    r_off;
    logic [31:0]   r_wdata, r_lo_word;
    logic          r_write, r_fault;
    logic [IW-1:0] r_hi_idx;

    assign w_fault  = ~w_legal | ~w_in_range;
    assign w_cross  = ({1'b0, w_off} + w_size) > 3'd4;
    assign w_hi_oor = (w_idx == IW'(DEPTH_WORDS - 1));
    assign w_split  = w_cross & ~w_fault;

    assign w_al_f3    = (r_state == ST_SPLIT_HI) ? r_f3      : req_funct3;
    assign w_al_off   = (r_state == ST_SPLIT_HI) ? r_off     : w_off;
    assign w_al_wdata = (r_state == ST_SPLIT_HI) ? r_wdata   : req_wdata;
    assign w_al_lo    = (r_state == ST_SPLIT_HI) ? r_lo_word : r_mem[w_idx];
    assign w_al_hi    = (r_state == ST_SPLIT_HI) ? r_mem[r_hi_idx] : '0;

    // A crossing store whose high word is out of range must not touch the low word either.
    always_comb begin
        w_we    = w_accept & req_write & ~w_fault & ~(w_cross & w_hi_oor);
        w_waddr = w_idx;
        w_wdata = w_st_lo;
        w_wbe   = w_be_lo;
        if (r_state == ST_SPLIT_HI) begin
            w_we    = ~reset & r_write & ~r_fault;
            w_waddr = r_hi_idx;
            w_wdata = w_st_hi;
            w_wbe   = w_be_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && w_split) begin
            r_f3      <= req_funct3;
            r_off     <= w_off;
            r_wdata   <= req_wdata;
            r_write   <= req_write;
            r_lo_word <= r_mem[w_idx];
            r_hi_idx  <= w_idx + IW'(1);
            r_fault   <= w_hi_oor;
        end
    end
`else
    logic w_aligned;
    logic w_unused;

    assign w_aligned  = (w_off & (w_size[1:0] - 2'd1)) == 2'd0;
    assign w_fault    = ~w_legal | ~w_in_range | ~w_aligned;
    assign w_al_f3    = req_funct3;
    assign w_al_off   = w_off;
    assign w_al_wdata = req_wdata;
    assign w_al_lo    = r_mem[w_idx];
    assign w_al_hi    = '0;
    assign w_we       = w_accept & req_write & ~w_fault;
    assign w_waddr    = w_idx;
    assign w_wdata    = w_st_lo;
    assign w_wbe      = w_be_lo;
    assign w_unused   = ^{w_st_hi, w_be_hi, w_size[2]};
`endif

    dmem_lane_align u_align (
        .i_funct3  (w_al_f3),
        .i_offset  (w_al_off),
        .i_wdata   (w_al_wdata),
        .i_lo_word (w_al_lo),
        .i_hi_word (w_al_hi),
        .o_st_lo   (w_st_lo),
        .o_st_hi   (w_st_hi),
        .o_be_lo   (w_be_lo),
        .o_be_hi   (w_be_hi),
        .o_ld_data (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wbe[b]) r_mem[w_waddr][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
                        if (w_split) begin
                            r_state <= ST_SPLIT_HI;
                        end else
`endif
                        begin
                            rsp_valid <= 1'b1;
                            rsp_fault <= w_fault;
                            rsp_rdata <= (w_fault | req_write) ? '0 : w_ld_data;
                        end
                    end
                end
`ifdef DMEM_MISALIGN_SPLIT_EN
                ST_SPLIT_HI: begin
                    r_state   <= ST_IDLE;
                    rsp_valid <= 1'b1;
                    rsp_fault <= r_fault;
                    rsp_rdata <= (r_fault | r_write) ? '0 : w_ld_data;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
